// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator sweep controller: FSM states,
// default widths and the phase-timer sizing helper.
package ro_ctrl_pkg;

    localparam int DEF_TAP_W   = 3;
    localparam int DEF_COUNT_W = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        WINDOW = 3'd3,
        SYNC   = 3'd4,
        REPORT = 3'd5,
        NEXT   = 3'd6
    } state_t;

    // The timer is loaded with (phase length - 1), so the longest phase sets the width.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ro_phase_timer.sv
// Loadable down-counter that times the SETTLE/WINDOW/SYNC phases; expired is
// high once the count has reached zero.
module ro_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ro_sweep_ctrl.sv
// Sweeps every ring-oscillator tap: clear, settle, count for a fixed window,
// wait for the count to synchronize, then hand the result to the consumer.
module ro_sweep_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int TAP_W      = DEF_TAP_W,
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int SETTLE_CYC = 16,
    parameter int WINDOW_CYC = 256,
    parameter int SYNC_CYC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] cnt_val,
    input  logic               res_ready,
    output logic [TAP_W-1:0]   ro_tap,
    output logic               ro_run,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic               res_valid,
    output logic [TAP_W-1:0]   res_tap,
    output logic [COUNT_W-1:0] res_count,
    output logic               res_ovf,
    output logic               busy,
    output logic               done
);

    localparam int TW = timer_width(SETTLE_CYC, WINDOW_CYC, SYNC_CYC);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] WINDOW_LD = TW'(WINDOW_CYC - 1);
    localparam logic [TW-1:0] SYNC_LD   = TW'(SYNC_CYC - 1);

    state_t             state, state_d;
    logic [TAP_W-1:0]   tap_d, res_tap_d;
    logic [COUNT_W-1:0] res_count_d;
    logic               res_valid_d, res_ovf_d, done_d;
    logic               run_d, clr_d, en_d, busy_d;
    logic               tmr_load, tmr_expired;
    logic [TW-1:0]      tmr_val;

    ro_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        tap_d       = ro_tap;
        res_valid_d = res_valid;
        res_tap_d   = res_tap;
        res_count_d = res_count;
        res_ovf_d   = res_ovf;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        if (abort) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tap_d   = '0;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
                SETTLE: begin
                    if (tmr_expired) begin
                        state_d  = WINDOW;
                        tmr_load = 1'b1;
                        tmr_val  = WINDOW_LD;
                    end
                end
                WINDOW: begin
                    if (tmr_expired) begin
                        state_d  = SYNC;
                        tmr_load = 1'b1;
                        tmr_val  = SYNC_LD;
                    end
                end
                SYNC: begin
                    if (tmr_expired) begin
                        state_d     = REPORT;
                        res_valid_d = 1'b1;
                        res_tap_d   = ro_tap;
                        res_count_d = cnt_val;
                        res_ovf_d   = &cnt_val;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state_d     = NEXT;
                        res_valid_d = 1'b0;
                        // done is registered, so it is raised while entering the final NEXT.
                        done_d      = &ro_tap;
                    end
                end
                NEXT: begin
                    if (&ro_tap) begin
                        state_d = IDLE;
                    end else begin
                        tap_d   = ro_tap + 1'b1;
                        state_d = CLEAR;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Ring controls are decoded from the next state and registered, so they stay glitch-free.
        run_d  = (state_d == CLEAR) || (state_d == SETTLE) || (state_d == WINDOW);
        clr_d  = (state_d == CLEAR);
        en_d   = (state_d == WINDOW);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ro_tap    <= '0;
            ro_run    <= 1'b0;
            cnt_clr   <= 1'b0;
            cnt_en    <= 1'b0;
            res_valid <= 1'b0;
            res_tap   <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            ro_tap    <= tap_d;
            ro_run    <= run_d;
            cnt_clr   <= clr_d;
            cnt_en    <= en_d;
            res_valid <= res_valid_d;
            res_tap   <= res_tap_d;
            res_count <= res_count_d;
            res_ovf   <= res_ovf_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Directed bench for ro_sweep_ctrl with default parameters: full sweep timing,
// consumer back-pressure, abort, overflow flag, ignored starts and async reset.
module tb_ro_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [14:0] cnt_val = '0;
    logic        res_ready = 1'b0;
    logic [2:0]  ro_tap;
    logic        ro_run, cnt_clr, cnt_en, res_valid, res_ovf, busy, done;
    logic [2:0]  res_tap;
    logic [14:0] res_count;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int done_cnt = 0;
    int took;

    ro_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cnt_val   (cnt_val),
        .res_ready (res_ready),
        .ro_tap    (ro_tap),
        .ro_run    (ro_run),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .res_valid (res_valid),
        .res_tap   (res_tap),
        .res_count (res_count),
        .res_ovf   (res_ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge; done pulses are tallied here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", res_valid, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ro_tap"},    ro_tap,    0);
        check({tag, "_ro_run"},    ro_run,    0);
        check({tag, "_cnt_clr"},   cnt_clr,   0);
        check({tag, "_cnt_en"},    cnt_en,    0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_tap"},   res_tap,   0);
        check({tag, "_res_count"}, res_count, 0);
        check({tag, "_res_ovf"},   res_ovf,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        #1 rst = 1'b1;
        #2;
        check_reset_values("por");
        ticks(2);
        rst = 1'b0;
        tick();

        // Scenario 1: full sweep, ready always high, constant count
        res_ready = 1'b1;
        cnt_val   = 15'd100;
        done_cnt  = 0;
        start = 1'b1; tick(); start = 1'b0;
        check("s1_clear_clr",  cnt_clr, 1);
        check("s1_clear_run",  ro_run,  1);
        check("s1_clear_en",   cnt_en,  0);
        check("s1_clear_busy", busy,    1);
        check("s1_clear_tap",  ro_tap,  0);
        tick();
        check("s1_settle_clr", cnt_clr, 0);
        check("s1_settle_run", ro_run,  1);
        check("s1_settle_en",  cnt_en,  0);
        ticks(15);
        check("s1_settle_last_en", cnt_en, 0);
        tick();
        check("s1_window_first_en",  cnt_en, 1);
        check("s1_window_first_run", ro_run, 1);
        ticks(255);
        check("s1_window_last_en", cnt_en, 1);
        tick();
        check("s1_sync_first_en",  cnt_en,    0);
        check("s1_sync_first_run", ro_run,    0);
        check("s1_sync_valid",     res_valid, 0);
        ticks(3);
        check("s1_sync_last_valid", res_valid, 0);
        tick();
        check("s1_t0_valid", res_valid, 1);
        check("s1_t0_tap",   res_tap,   0);
        check("s1_t0_count", res_count, 100);
        check("s1_t0_ovf",   res_ovf,   0);
        check("s1_t0_run",   ro_run,    0);
        tick();
        check("s1_next_valid", res_valid, 0);
        check("s1_next_tap",   ro_tap,    0);
        check("s1_next_busy",  busy,      1);
        check("s1_next_done",  done,      0);
        tick();
        check("s1_t1_tap",     ro_tap,  1);
        check("s1_t1_clr",     cnt_clr, 1);
        for (int t = 1; t < 8; t++) begin
            wait_valid(400, took);
            check("s1_lat",   took,      277);
            check("s1_tap",   res_tap,   t);
            check("s1_count", res_count, 100);
            check("s1_ovf",   res_ovf,   0);
            tick();
            if (t < 7) begin
                tick();
                check("s1_tap_step", ro_tap, t + 1);
            end
        end
        check("s1_done_pulse", done, 1);
        tick();
        check("s1_idle_busy", busy,     0);
        check("s1_idle_done", done,     0);
        check("s1_idle_run",  ro_run,   0);
        check("s1_done_cnt",  done_cnt, 1);

        // Scenario 2: consumer stalls for 10 cycles at tap 3
        done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wait_valid(400, took);
            check("s2_tap", res_tap, t);
            tick();
            if (t == 2) res_ready = 1'b0;
            tick();
        end
        cnt_val = 15'h1234;
        wait_valid(400, took);
        check("s2_lat", took, 277);
        cnt_val = 15'h0555;
        for (int i = 0; i < 10; i++) begin
            check("s2_hold_valid", res_valid, 1);
            check("s2_hold_tap",   res_tap,   3);
            check("s2_hold_count", res_count, 15'h1234);
            check("s2_hold_rotap", ro_tap,    3);
            check("s2_hold_run",   ro_run,    0);
            if (i == 9) res_ready = 1'b1;
            tick();
        end
        check("s2_released", res_valid, 0);
        tick();
        check("s2_t4_tap", ro_tap, 4);
        cnt_val = 15'd100;

        // Scenario 3: abort in WINDOW at tap 5
        wait_valid(400, took);
        check("s3_t4_tap", res_tap, 4);
        ticks(2);
        check("s3_t5_tap", ro_tap, 5);
        ticks(17);
        check("s3_in_window", cnt_en, 1);
        ticks(10);
        abort = 1'b1; tick(); abort = 1'b0;
        check("s3_busy",  busy,      0);
        check("s3_en",    cnt_en,    0);
        check("s3_run",   ro_run,    0);
        check("s3_valid", res_valid, 0);
        check("s3_done",  done,      0);
        ticks(5);
        check("s3_done_cnt", done_cnt, 0);
        check("s3_stay_idle", busy, 0);

        // Scenario 4 + 5a: restart at tap 0 with saturated count; start while busy ignored
        cnt_val = 15'h7FFF;
        start = 1'b1; tick(); start = 1'b0;
        check("s4_restart_tap", ro_tap,  0);
        check("s4_restart_clr", cnt_clr, 1);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("s5_busy_start_clr", cnt_clr, 0);
        check("s5_busy_start_tap", ro_tap,  0);
        check("s5_busy_start_run", ro_run,  1);
        wait_valid(400, took);
        check("s5_lat",   took,      275);
        check("s4_ovf",   res_ovf,   1);
        check("s4_count", res_count, 15'h7FFF);
        check("s4_tap",   res_tap,   0);
        ticks(2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("s5_abort_idle", busy, 0);

        // Scenario 5b: start together with abort in IDLE
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("s5_sa_busy", busy,    0);
        check("s5_sa_clr",  cnt_clr, 0);
        check("s5_sa_run",  ro_run,  0);
        tick();
        check("s5_sa_stay", busy, 0);

        // Scenario 6: asynchronous reset during SETTLE of tap 1
        cnt_val = 15'd100;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(400, took);
        ticks(4);
        check("s6_pre_tap", ro_tap, 1);
        check("s6_pre_run", ro_run, 1);
        check("s6_pre_cnt", res_count, 100);
        rst = 1'b1;
        #2;
        check_reset_values("s6");
        tick();
        rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("s6_restart_tap",  ro_tap,  0);
        check("s6_restart_clr",  cnt_clr, 1);
        check("s6_restart_busy", busy,    1);
        abort = 1'b1; tick(); abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ro_sweep_ctrl.md
RO_SWEEP_CTRL -- requirements
Module: ro_sweep_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, default 3: width of the ring tap select; the sweep covers taps 0..2^TAP_W-1.
REQ-002 SHALL have parameter COUNT_W, default 15: width of the oscillator edge counter result.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: clk cycles the ring runs, uncounted, after a tap change.
REQ-004 SHALL have parameter WINDOW_CYC, default 256: clk cycles of the counting window.
REQ-005 SHALL have parameter SYNC_CYC, default 4: clk cycles waited after window close before cnt_val is sampled.
REQ-006 SHALL have port clk  in  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a full tap sweep.
REQ-009 SHALL have port abort  in  1  terminate any sweep immediately.
REQ-010 SHALL have port cnt_val  in  COUNT_W  oscillator count, already synchronized into clk domain.
REQ-011 SHALL have port res_ready  in  1  result consumer ready.
REQ-012 SHALL have port ro_tap  out  TAP_W  tap select to the ring.
REQ-013 SHALL have port ro_run  out  1  ring enable (oscillate).
REQ-014 SHALL have port cnt_clr  out  1  one-cycle counter clear pulse.
REQ-015 SHALL have port cnt_en  out  1  counter gate, high only during the window.
REQ-016 SHALL have port res_valid, res_tap (TAP_W), res_count (COUNT_W), res_ovf (1)  out  result beat.
REQ-017 SHALL have port busy  out  1  high in any state other than IDLE; done  out  1  one-cycle pulse at sweep end.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, SETTLE, WINDOW, SYNC, REPORT, NEXT.
REQ-019 In IDLE, start=1 SHALL load ro_tap=0 and enter CLEAR next cycle; start at any other time SHALL be ignored.
REQ-020 CLEAR SHALL last exactly 1 cycle, with cnt_clr=1 and ro_run=1, then enter SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, with ro_run=1 and cnt_en=0, then enter WINDOW.
REQ-022 WINDOW SHALL last exactly WINDOW_CYC cycles, with ro_run=1 and cnt_en=1, then enter SYNC.
REQ-023 SYNC SHALL last exactly SYNC_CYC cycles, with cnt_en=0 and ro_run=0; on its last cycle cnt_val SHALL be registered into res_count, and ro_tap into res_tap.
REQ-024 res_ovf SHALL be 1 iff the captured cnt_val equals all-ones (counter saturated/wrapped risk).
REQ-025 REPORT SHALL hold res_valid=1 with stable res_* until a cycle with res_ready=1; that cycle completes the transfer and the FSM enters NEXT.
REQ-026 res_ready=1 already present on REPORT entry SHALL complete the transfer in that first REPORT cycle.
REQ-027 NEXT (1 cycle): if ro_tap is all-ones, SHALL pulse done=1 and return to IDLE; otherwise SHALL increment ro_tap and enter CLEAR (no tap wrap to 0 within a sweep).
REQ-028 abort=1 in any state SHALL force IDLE on the next edge, deassert ro_run/cnt_en/res_valid, and SHALL NOT pulse done; abort has priority over start and res_ready.
REQ-029 The sweep per tap SHALL take exactly 1+SETTLE_CYC+WINDOW_CYC+SYNC_CYC+R+1 cycles, where R≥1 is the REPORT duration.
REQ-030 Phase timing SHALL use one down-counter sized for max(SETTLE_CYC,WINDOW_CYC,SYNC_CYC); parameters below 1 are illegal.
REQ-031 All outputs SHALL be registered; cnt_clr, cnt_en and ro_run SHALL be glitch-free.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, ro_tap=0, ro_run=0, cnt_clr=0, cnt_en=0, res_valid=0, res_tap=0, res_count=0, res_ovf=0, busy=0, done=0, timer=0.
REQ-033 Reset asserted mid-sweep SHALL behave as abort but take effect immediately; the first start after deassertion SHALL begin at tap 0.

Structure
REQ-034 A shared package ro_ctrl_pkg SHALL hold the FSM state enum and the default TAP_W/COUNT_W constants.
REQ-035 The phase timer SHALL be one sub-module ro_phase_timer (load value, load strobe, expire flag).

Verification
REQ-036 Scenario 1: rst, start pulse, res_ready=1, cnt_val=100 constant -> 8 results, taps 0..7 in order, res_count=100, res_ovf=0, one done pulse; per-tap period = 1+16+256+4+1+1 = 279 cycles.
REQ-037 Scenario 2: res_ready=0 for 10 cycles at tap 3 -> res_valid held 10 cycles, res_* stable, then transfer; ro_tap stays 3, ro_run=0 meanwhile.
REQ-038 Scenario 3: abort asserted in WINDOW at tap 5 -> next cycle IDLE, cnt_en=0, ro_run=0, no done; a new start restarts at tap 0.
REQ-039 Scenario 4: cnt_val=0x7FFF at capture -> res_ovf=1, res_count=0x7FFF.
REQ-040 Scenario 5: start pulsed while busy, and start+abort asserted together in IDLE -> both ignored; sweep unaffected or FSM stays IDLE.
REQ-041 Scenario 6: rst asserted during SETTLE -> all outputs at REQ-032 values within the same cycle, without waiting for a clk edge.
